// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared types and constants for the execute-stage controller.
//  Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam int OP_W = 3;
    localparam int RA_W = 5;

    // Operand source encoding for the ALU operand muxes
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            we;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_unit
//  Purpose  : Operand source select for one ALU operand (rs vs in-flight rd).
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_unit #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic            i_ex_valid,
    input  logic            i_ex_we,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_wb_valid,
    input  logic            i_wb_we,
    input  logic [RA_W-1:0] i_wb_rd,
    output logic [1:0]      o_sel
);
    import ex_pkg::*;

    // EX is younger than WB, so it wins when both match; x0 is hardwired zero
    always_comb begin
        o_sel = FWD_RF;
        if (i_rs == '0)
            o_sel = FWD_RF;
        else if (i_ex_valid && i_ex_we && (i_ex_rd == i_rs))
            o_sel = FWD_EX;
        else if (i_wb_valid && i_wb_we && (i_wb_rd == i_rs))
            o_sel = FWD_WB;
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_ctrl
//  Purpose  : Execute-stage issue/sequencing control: EX/WB occupancy,
//             forwarding selects, decode back-pressure, flush, stall count.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage_ctrl #(
    parameter int OP_W  = ex_pkg::OP_W,
    parameter int RA_W  = ex_pkg::RA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [OP_W-1:0]  dec_alu_op,
    input  logic [RA_W-1:0]  dec_rs1,
    input  logic [RA_W-1:0]  dec_rs2,
    input  logic [RA_W-1:0]  dec_rd,
    input  logic             dec_we,
    input  logic             flush,
    input  logic             wb_ack,
    output logic             ex_load,
    output logic             ex_valid,
    output logic [OP_W-1:0]  ex_alu_op,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_we,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             wb_valid,
    output logic [RA_W-1:0]  wb_rd,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt
);
    import ex_pkg::*;

    stage_t           r_ex;
    stage_t           r_wb;
    logic [OP_W-1:0]  r_ex_op;
    logic [1:0]       r_fwd1;
    logic [1:0]       r_fwd2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_wb_free;
    logic       w_ex_adv;
    logic       w_ready;
    logic       w_load;
    logic       w_move;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;

    assign w_wb_free = !r_wb.valid || wb_ack;
    assign w_ex_adv  = r_ex.valid && w_wb_free;
    // Ready is forced low during reset so no output toggles while rst is held
    assign w_ready   = !rst && !flush && (!r_ex.valid || w_ex_adv);
    assign w_load    = dec_valid && w_ready;
    assign w_move    = w_ex_adv && !flush;

    fwd_unit #(.RA_W(RA_W)) u_fwd1 (
        .i_rs       (dec_rs1),
        .i_ex_valid (r_ex.valid),
        .i_ex_we    (r_ex.we),
        .i_ex_rd    (r_ex.rd),
        .i_wb_valid (r_wb.valid),
        .i_wb_we    (r_wb.we),
        .i_wb_rd    (r_wb.rd),
        .o_sel      (w_sel1)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd2 (
        .i_rs       (dec_rs2),
        .i_ex_valid (r_ex.valid),
        .i_ex_we    (r_ex.we),
        .i_ex_rd    (r_ex.rd),
        .i_wb_valid (r_wb.valid),
        .i_wb_we    (r_wb.we),
        .i_wb_rd    (r_wb.rd),
        .o_sel      (w_sel2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= '0;
            r_wb        <= '0;
            r_ex_op     <= '0;
            r_fwd1      <= FWD_RF;
            r_fwd2      <= FWD_RF;
            r_stall_cnt <= '0;
        end else begin
            if (w_load) begin
                r_ex    <= '{valid: 1'b1, rd: dec_rd, we: dec_we};
                r_ex_op <= dec_alu_op;
                r_fwd1  <= w_sel1;
                r_fwd2  <= w_sel2;
            end else if (flush || w_ex_adv) begin
                r_ex.valid <= 1'b0;
                r_ex.we    <= 1'b0;
            end

            // A flushed EX entry never moves, so its write cannot reach WB
            if (w_move) begin
                r_wb <= r_ex;
            end else if (wb_ack) begin
                r_wb.valid <= 1'b0;
                r_wb.we    <= 1'b0;
            end

            if (dec_valid && !w_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign dec_ready = w_ready;
    assign ex_load   = w_load;
    assign ex_valid  = r_ex.valid;
    assign ex_alu_op = r_ex_op;
    assign ex_rd     = r_ex.rd;
    assign ex_we     = r_ex.we;
    assign fwd_sel1  = r_fwd1;
    assign fwd_sel2  = r_fwd2;
    assign wb_valid  = r_wb.valid;
    assign wb_rd     = r_wb.rd;
    assign wb_we     = r_wb.we;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
